// File: rtl/sd_host_pkg.sv
// Shared types and constants for the SD host command-line engine.
package sd_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_GAP
  } state_e;

  // Response type 2 is the unchecked R3 frame and type 3 is the long R2 frame.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R3   = 2'd2,
    RESP_R2   = 2'd3
  } resp_type_e;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int         CMD_LEN   = 48;
  localparam int         LONG_LEN  = 136;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enable, zero initial value.
module sd_crc7
  import sd_host_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);
  logic fb;

  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     crc <= '0;
    else if (clear)  crc <= '0;
    else if (enable) crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/sd_host_cmd.sv
// Host-side SD CMD line engine: serialises a 48-bit command, then captures
// and checks the card's response on the shared CMD line.
module sd_host_cmd
  import sd_host_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int NCC_MIN = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         sd_clk_en,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         done,
  output logic [135:0] resp,
  output logic         crc_err,
  output logic         timeout,
  output logic         end_err,
  output logic         index_err,
  inout  wire          sd_cmd
);
  localparam logic [15:0] NCR_LAST = 16'(NCR_MAX - 1);
  localparam logic [15:0] NCC_LAST = 16'(NCC_MIN - 1);

  state_e       state;
  resp_type_e   rt_q;
  logic [5:0]   idx_q;
  logic [39:0]  tx_sr;
  logic [15:0]  cnt;
  logic         cmd_oe, cmd_out;
  logic         sync1, sync2;
  logic         crc_clr, crc_en, crc_bit;
  logic [6:0]   crc;
  logic [15:0]  rx_last;
  logic         rx_crc_win;
  logic [135:0] resp_nxt;
  logic [2:0]   crc_sel;

  assign sd_cmd = cmd_oe ? cmd_out : 1'bz;

  // In RX, cnt is the number of bits already taken (start bit included).
  // The long frame's CRC skips its 8 header bits.
  assign rx_last    = (rt_q == RESP_R2) ? 16'(LONG_LEN - 1) : 16'(CMD_LEN - 1);
  assign rx_crc_win = (cnt <= rx_last - 16'd8) && ((rt_q != RESP_R2) || (cnt >= 16'd8));
  assign resp_nxt   = {resp[134:0], sync2};
  assign crc_sel    = 3'(16'd46 - cnt);

  assign crc_clr = (state == S_IDLE) || (state == S_WAIT);
  assign crc_en  = sd_clk_en && (((state == S_TX) && (cnt < 16'd40)) ||
                                 ((state == S_RX) && rx_crc_win));
  assign crc_bit = (state == S_TX) ? tx_sr[39] : sync2;

  sd_crc7 u_crc (
    .clk    (clk),
    .resetn (resetn),
    .clear  (crc_clr),
    .enable (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      rt_q      <= RESP_NONE;
      idx_q     <= '0;
      tx_sr     <= '0;
      cnt       <= '0;
      cmd_oe    <= 1'b0;
      cmd_out   <= 1'b1;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      resp      <= '0;
      crc_err   <= 1'b0;
      timeout   <= 1'b0;
      end_err   <= 1'b0;
      index_err <= 1'b0;
    end else begin
      sync1 <= sd_cmd;
      sync2 <= sync1;
      done  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          rt_q      <= resp_type_e'(resp_type);
          idx_q     <= cmd_index;
          tx_sr     <= {2'b01, cmd_index, cmd_arg};
          cnt       <= '0;
          resp      <= '0;
          crc_err   <= 1'b0;
          timeout   <= 1'b0;
          end_err   <= 1'b0;
          index_err <= 1'b0;
          busy      <= 1'b1;
          state     <= S_TX;
        end
        S_TX: if (sd_clk_en) begin
          cnt <= cnt + 16'd1;
          if (cnt < 16'd40) begin
            cmd_oe  <= 1'b1;
            cmd_out <= tx_sr[39];
            tx_sr   <= {tx_sr[38:0], 1'b0};
          end else if (cnt < 16'd47) begin
            cmd_out <= crc[crc_sel];
          end else if (cnt == 16'd47) begin
            cmd_out <= 1'b1;
          end else begin
            cmd_oe <= 1'b0;
            cnt    <= '0;
            if (rt_q == RESP_NONE) begin
              done  <= 1'b1;
              state <= S_GAP;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: if (sd_clk_en) begin
          if (!sync2) begin
            resp  <= resp_nxt;
            cnt   <= 16'd1;
            state <= S_RX;
          end else if (cnt == NCR_LAST) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            cnt     <= '0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RX: if (sd_clk_en) begin
          resp <= resp_nxt;
          cnt  <= cnt + 16'd1;
          if (cnt == rx_last) begin
            end_err <= !sync2;
            if (rt_q == RESP_R1) begin
              crc_err   <= (crc != resp_nxt[7:1]);
              index_err <= (resp_nxt[45:40] != idx_q);
            end else if (rt_q == RESP_R2) begin
              crc_err <= (crc != resp_nxt[7:1]);
            end
            done  <= 1'b1;
            cnt   <= '0;
            state <= S_GAP;
          end
        end
        S_GAP: if (sd_clk_en) begin
          if (cnt == NCC_LAST) begin
            busy  <= 1'b0;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_host_cmd.sv
// Bench for sd_host_cmd: a card model on the CMD line plus a scoreboard of
// expected frames, responses, flags and pulse timing.
module tb_sd_host_cmd;
  logic         clk = 1'b0, resetn = 1'b0, sd_clk_en = 1'b0, start = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   resp_type = '0;
  logic         busy, done, crc_err, timeout, end_err, index_err;
  logic [135:0] resp;
  wire          sd_cmd;
  logic         dev_oe = 1'b0, dev_bit = 1'b1;
  logic         was_en = 1'b0, tie_en = 1'b0;
  int           n_chk = 0, n_fail = 0, div = 0;

  typedef struct {
    logic [47:0]  txf;
    logic [135:0] resp;
    logic [3:0]   flags;
    int           done_cnt;
    int           done_np;
    int           idle_np;
  } res_t;

  res_t sb[$];

  assign sd_cmd = dev_oe ? dev_bit : 1'bz;
  pullup (sd_cmd);

  always #5 clk = ~clk;

  sd_host_cmd #(.NCR_MAX(64), .NCC_MIN(8)) dut (
    .clk(clk), .resetn(resetn), .sd_clk_en(sd_clk_en), .start(start),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type),
    .busy(busy), .done(done), .resp(resp), .crc_err(crc_err), .timeout(timeout),
    .end_err(end_err), .index_err(index_err), .sd_cmd(sd_cmd)
  );

  function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] frame48(input logic [1:0] hdr, input logic [5:0] idx, input logic [31:0] arg);
    logic [135:0] v;
    v      = {88'b0, hdr, idx, arg, 8'h01};
    v[7:1] = crc7(v, 47, 8);
    return v[47:0];
  endfunction

  // Inputs change and outputs are sampled on the falling edge; was_en is the
  // enable the preceding rising edge used.
  task automatic tick();
    @(negedge clk);
    was_en    = sd_clk_en;
    div       = div + 1;
    sd_clk_en = tie_en || (div % 4 == 0);
  endtask

  // Issues one command and plays the card: reply start bit goes out dly
  // periods after the release pulse (pulse 49). Pulse numbers count from start.
  task automatic do_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic [135:0] reply, input int rlen, input int dly,
                        input bit poke, output res_t o);
    int np, k;
    o = '{txf: '0, resp: '0, flags: '0, done_cnt: 0, done_np: -1, idle_np: -1};
    np = 0;
    start = 1'b1; cmd_index = idx; cmd_arg = arg; resp_type = rt;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (was_en) np++;
      if (done) begin
        o.done_cnt++;
        o.done_np = np;
        o.resp    = resp;
        o.flags   = {crc_err, timeout, end_err, index_err};
      end
      if (!busy) begin
        o.idle_np = np;
        break;
      end
      if (was_en && np <= 48) o.txf = {o.txf[46:0], sd_cmd};
      if (poke && was_en && np == 20) begin
        start = 1'b1; cmd_index = ~idx;
      end else begin
        start = 1'b0;
      end
      if (was_en) begin
        k       = np - 49 - dly;
        dev_oe  = (rlen > 0) && (k >= 0) && (k < rlen);
        dev_bit = dev_oe ? reply[rlen - 1 - k] : 1'b1;
      end
    end
    dev_oe = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_chk++; if (resp !== '0) begin n_fail++; $display("FAIL reset_resp got=%h exp=0", resp); end
    n_chk++; if ({crc_err, timeout, end_err, index_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {crc_err, timeout, end_err, index_err}); end
    dev_oe = 1'b1; dev_bit = 1'b0; #1;
    n_chk++; if (sd_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_release got=%b exp=0", sd_cmd); end
    dev_oe = 1'b0;
    resetn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_no_resp();
    res_t e, o;
    for (int i = 0; i < 2; i++) begin
      tie_en = (i == 1);
      e = '{txf: 48'h400000000095, resp: '0, flags: 4'b0, done_cnt: 1, done_np: 49, idle_np: 57};
      sb.push_back(e);
      do_txn(6'd0, 32'h0, 2'd0, '0, 0, 0, 1'b0, o);
      e = sb.pop_front();
      n_chk++; if (o.txf !== e.txf) begin n_fail++; $display("FAIL noresp%0d tx_frame got=%h exp=%h", i, o.txf, e.txf); end
      n_chk++; if (o.resp !== e.resp) begin n_fail++; $display("FAIL noresp%0d resp got=%h exp=%h", i, o.resp, e.resp); end
      n_chk++; if (o.flags !== e.flags) begin n_fail++; $display("FAIL noresp%0d flags got=%b exp=%b", i, o.flags, e.flags); end
      n_chk++; if (o.done_cnt != e.done_cnt) begin n_fail++; $display("FAIL noresp%0d done_count got=%0d exp=%0d", i, o.done_cnt, e.done_cnt); end
      n_chk++; if (o.done_np != e.done_np) begin n_fail++; $display("FAIL noresp%0d done_pulse got=%0d exp=%0d", i, o.done_np, e.done_np); end
      n_chk++; if (o.idle_np != e.idle_np) begin n_fail++; $display("FAIL noresp%0d idle_pulse got=%0d exp=%0d", i, o.idle_np, e.idle_np); end
    end
    tie_en = 1'b0;
  endtask

  task automatic test_r1();
    res_t e, o;
    logic [47:0] rep;
    int dly, rlen;
    for (int i = 0; i < 5; i++) begin
      dly = 5; rlen = 48;
      e = '{txf: 48'h48000001AA87, resp: '0, flags: 4'b0, done_cnt: 1, done_np: 102, idle_np: 110};
      case (i)
        0: rep = 48'h08000001AA13;
        1: begin rep = 48'h08000001AA15; e.flags = 4'b1000; end
        2: begin rep = frame48(2'b00, 6'd9, 32'h1AA); e.flags = 4'b0001; end
        3: begin rep = '0; rlen = 0; e.flags = 4'b0100; e.done_np = 113; e.idle_np = 121; end
        default: begin rep = 48'h08000001AA13; dly = 63; e.done_np = 160; e.idle_np = 168; end
      endcase
      if (rlen > 0) e.resp = {88'b0, rep};
      sb.push_back(e);
      do_txn(6'd8, 32'h1AA, 2'd1, {88'b0, rep}, rlen, dly, 1'b0, o);
      e = sb.pop_front();
      n_chk++; if (o.txf !== e.txf) begin n_fail++; $display("FAIL r1_%0d tx_frame got=%h exp=%h", i, o.txf, e.txf); end
      n_chk++; if (o.resp !== e.resp) begin n_fail++; $display("FAIL r1_%0d resp got=%h exp=%h", i, o.resp, e.resp); end
      n_chk++; if (o.flags !== e.flags) begin n_fail++; $display("FAIL r1_%0d flags got=%b exp=%b", i, o.flags, e.flags); end
      n_chk++; if (o.done_cnt != e.done_cnt) begin n_fail++; $display("FAIL r1_%0d done_count got=%0d exp=%0d", i, o.done_cnt, e.done_cnt); end
      n_chk++; if (o.done_np != e.done_np) begin n_fail++; $display("FAIL r1_%0d done_pulse got=%0d exp=%0d", i, o.done_np, e.done_np); end
      n_chk++; if (o.idle_np != e.idle_np) begin n_fail++; $display("FAIL r1_%0d idle_pulse got=%0d exp=%0d", i, o.idle_np, e.idle_np); end
    end
  endtask

  task automatic test_long();
    res_t e, o;
    logic [135:0] rep, cid_frame;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rt;
    int rlen, dly;
    cid_frame      = {8'h3F, 120'h0353_4453_4431_3647_803A_4B1C_55E0_AA, 8'h01};
    cid_frame[7:1] = crc7(cid_frame, 127, 8);
    for (int i = 0; i < 3; i++) begin
      idx = 6'd41; arg = 32'h40FF8000; rt = 2'd2; rlen = 48; dly = 5;
      e = '{txf: frame48(2'b01, 6'd41, 32'h40FF8000), resp: '0, flags: 4'b0,
            done_cnt: 1, done_np: 102, idle_np: 110};
      case (i)
        0: rep = {88'b0, 48'h3F00FF8000FF};
        1: begin rep = {88'b0, 48'h3F00FF8000FE}; e.flags = 4'b0010; end
        default: begin
          idx = 6'd2; arg = 32'h0; rt = 2'd3; rlen = 136; dly = 0; rep = cid_frame;
          e.txf = frame48(2'b01, 6'd2, 32'h0); e.done_np = 185; e.idle_np = 193;
        end
      endcase
      e.resp = rep;
      sb.push_back(e);
      do_txn(idx, arg, rt, rep, rlen, dly, 1'b0, o);
      e = sb.pop_front();
      n_chk++; if (o.txf !== e.txf) begin n_fail++; $display("FAIL long%0d tx_frame got=%h exp=%h", i, o.txf, e.txf); end
      n_chk++; if (o.resp !== e.resp) begin n_fail++; $display("FAIL long%0d resp got=%h exp=%h", i, o.resp, e.resp); end
      n_chk++; if (o.flags !== e.flags) begin n_fail++; $display("FAIL long%0d flags got=%b exp=%b", i, o.flags, e.flags); end
      n_chk++; if (o.done_cnt != e.done_cnt) begin n_fail++; $display("FAIL long%0d done_count got=%0d exp=%0d", i, o.done_cnt, e.done_cnt); end
      n_chk++; if (o.done_np != e.done_np) begin n_fail++; $display("FAIL long%0d done_pulse got=%0d exp=%0d", i, o.done_np, e.done_np); end
      n_chk++; if (o.idle_np != e.idle_np) begin n_fail++; $display("FAIL long%0d idle_pulse got=%0d exp=%0d", i, o.idle_np, e.idle_np); end
    end
  endtask

  // First command gets a stray start mid-TX; the second follows immediately.
  task automatic test_back_to_back();
    res_t e, o;
    logic [47:0] rep;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        rep = frame48(2'b00, 6'd55, 32'h120);
        e = '{txf: frame48(2'b01, 6'd55, 32'h0), resp: {88'b0, rep}, flags: 4'b0,
              done_cnt: 1, done_np: 99, idle_np: 107};
        sb.push_back(e);
        do_txn(6'd55, 32'h0, 2'd1, {88'b0, rep}, 48, 2, 1'b1, o);
      end else begin
        rep = 48'h08000001AA13;
        e = '{txf: 48'h48000001AA87, resp: {88'b0, rep}, flags: 4'b0,
              done_cnt: 1, done_np: 102, idle_np: 110};
        sb.push_back(e);
        do_txn(6'd8, 32'h1AA, 2'd1, {88'b0, rep}, 48, 5, 1'b0, o);
      end
      e = sb.pop_front();
      n_chk++; if (o.txf !== e.txf) begin n_fail++; $display("FAIL b2b%0d tx_frame got=%h exp=%h", i, o.txf, e.txf); end
      n_chk++; if (o.resp !== e.resp) begin n_fail++; $display("FAIL b2b%0d resp got=%h exp=%h", i, o.resp, e.resp); end
      n_chk++; if (o.flags !== e.flags) begin n_fail++; $display("FAIL b2b%0d flags got=%b exp=%b", i, o.flags, e.flags); end
      n_chk++; if (o.done_cnt != e.done_cnt) begin n_fail++; $display("FAIL b2b%0d done_count got=%0d exp=%0d", i, o.done_cnt, e.done_cnt); end
      n_chk++; if (o.done_np != e.done_np) begin n_fail++; $display("FAIL b2b%0d done_pulse got=%0d exp=%0d", i, o.done_np, e.done_np); end
      n_chk++; if (o.idle_np != e.idle_np) begin n_fail++; $display("FAIL b2b%0d idle_pulse got=%0d exp=%0d", i, o.idle_np, e.idle_np); end
    end
  endtask

  // Reset lands while the DUT drives the '1' transmission bit; the card then
  // pulls low, which only shows on the line if the host has let go.
  task automatic test_reset_mid_tx();
    res_t e, o;
    int np, dn;
    np = 0; dn = 0;
    start = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h1AA; resp_type = 2'd1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && np < 2; c++) begin
      tick();
      if (was_en) np++;
    end
    resetn = 1'b0; #1;
    dev_oe = 1'b1; dev_bit = 1'b0; #1;
    n_chk++; if (sd_cmd !== 1'b0) begin n_fail++; $display("FAIL midrst_release got=%b exp=0", sd_cmd); end
    dev_oe = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    repeat (6) begin tick(); if (done) dn++; end
    resetn = 1'b1;
    repeat (40) begin tick(); if (done) dn++; end
    n_chk++; if (dn != 0) begin n_fail++; $display("FAIL midrst_done got=%0d exp=0", dn); end
    e = '{txf: 48'h400000000095, resp: '0, flags: 4'b0, done_cnt: 1, done_np: 49, idle_np: 57};
    sb.push_back(e);
    do_txn(6'd0, 32'h0, 2'd0, '0, 0, 0, 1'b0, o);
    e = sb.pop_front();
    n_chk++; if (o.txf !== e.txf) begin n_fail++; $display("FAIL midrst_next tx_frame got=%h exp=%h", o.txf, e.txf); end
    n_chk++; if (o.flags !== e.flags) begin n_fail++; $display("FAIL midrst_next flags got=%b exp=%b", o.flags, e.flags); end
    n_chk++; if (o.done_cnt != e.done_cnt) begin n_fail++; $display("FAIL midrst_next done_count got=%0d exp=%0d", o.done_cnt, e.done_cnt); end
    n_chk++; if (o.done_np != e.done_np) begin n_fail++; $display("FAIL midrst_next done_pulse got=%0d exp=%0d", o.done_np, e.done_np); end
    n_chk++; if (o.idle_np != e.idle_np) begin n_fail++; $display("FAIL midrst_next idle_pulse got=%0d exp=%0d", o.idle_np, e.idle_np); end
  endtask

  initial begin
    test_reset();
    test_no_resp();
    test_r1();
    test_long();
    test_back_to_back();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
